// File: rtl/uart_rx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_ctrl_pkg
//  Description : Shared definitions for the UART receive controller:
//                configuration FSM state encoding, ERR_STATUS bit positions
//                and the error-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_ctrl_pkg;

    // Configuration hand-shake FSM
    typedef enum logic [1:0] {
        CFG_IDLE  = 2'd0,
        CFG_WAIT  = 2'd1,
        CFG_APPLY = 2'd2
    } cfg_state_t;

    // ERR_STATUS layout: {drop, overrun, frame, parity}
    localparam int c_err_bit_parity  = 0;
    localparam int c_err_bit_frame   = 1;
    localparam int c_err_bit_overrun = 2;
    localparam int c_err_bit_drop    = 3;

    // Width of the optional saturating error counters
    localparam int c_err_cnt_w = 8;

endpackage : uart_rx_ctrl_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Small synchronous receive buffer with first-word fall-through
//                output. A pop on an empty buffer is ignored; a push while full
//                is accepted only when a pop frees a slot in the same cycle.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                i_push, i_data - write request and word
//                i_pop          - read request (advances the head)
//                o_data         - head word
//                o_full/o_empty - occupancy flags
//                o_count        - occupancy, 0..FIFO_DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [DATA_WIDTH-1:0]         i_data,
    input  logic                          i_pop,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0] c_full_count = (c_ptr_w+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w:0]      r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_full_count);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // When full, the write slot equals the head slot; a concurrent pop frees it
    // at the same edge, so the write is safe.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_ptr_w+1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : uart_rx_fifo
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_ctrl
//  Description : UART receive-side controller. Buffers completed words in a
//                FIFO, collects sticky error status, and applies parity
//                configuration changes only while the receiver is idle.
//  Ports       : CLK/RESET                 - clock, async active-high reset
//                RX_DONE/RX_DATA_IN/RX_BUSY - receiver word/status inputs
//                *_ERROR_IN                 - receiver error flags
//                CFG_REQ/CFG_ACK/CFG_*      - configuration hand-shake
//                PARITY_EN/PARITY_MODE      - applied configuration
//                DATA_OUT/DATA_VALID/DATA_READY - consumer stream
//                FIFO_COUNT/FIFO_FULL/DROP  - buffer status
//                ERR_STATUS/ERR_CLR         - sticky {drop,overrun,frame,parity}
//                FRAME_ERR_CNT/PARITY_ERR_CNT - saturating counters
//  Options     : define UART_RX_CTRL_ERR_CNT_EN to include the error counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          RX_DONE,
    input  logic [DATA_WIDTH-1:0]         RX_DATA_IN,
    input  logic                          RX_BUSY,
    input  logic                          PARITY_ERROR_IN,
    input  logic                          FRAME_ERROR_IN,
    input  logic                          OVERRUN_ERROR_IN,
    input  logic                          CFG_REQ,
    input  logic                          CFG_PARITY_EN,
    input  logic                          CFG_PARITY_MODE,
    output logic                          CFG_ACK,
    output logic                          PARITY_EN,
    output logic                          PARITY_MODE,
    output logic [DATA_WIDTH-1:0]         DATA_OUT,
    output logic                          DATA_VALID,
    input  logic                          DATA_READY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          FIFO_FULL,
    output logic                          DROP,
    output logic [3:0]                    ERR_STATUS,
    input  logic                          ERR_CLR
`ifdef UART_RX_CTRL_ERR_CNT_EN
    ,
    output logic [c_err_cnt_w-1:0]        FRAME_ERR_CNT,
    output logic [c_err_cnt_w-1:0]        PARITY_ERR_CNT
`endif
);

    // Edge-detect history
    logic r_rx_done_d;
    logic r_frame_d;
    logic r_parity_d;
    logic r_overrun_d;
    logic r_rx_busy_d;

    logic w_push;
    logic w_pop;
    logic w_empty;
    logic w_full;
    logic w_drop_evt;
    logic w_frame_rise;
    logic w_parity_rise;
    logic w_overrun_rise;
    logic [3:0] w_err_set;

    logic       r_drop;
    logic [3:0] r_err_status;
    cfg_state_t r_cfg_state;
    logic       r_cfg_ack;
    logic       r_parity_en;
    logic       r_parity_mode;

    assign w_push         = RX_DONE & ~r_rx_done_d;
    assign w_pop          = DATA_READY & ~w_empty;
    assign w_drop_evt     = w_push & w_full & ~w_pop;
    assign w_frame_rise   = FRAME_ERROR_IN & ~r_frame_d;
    assign w_parity_rise  = PARITY_ERROR_IN & ~r_parity_d;
    assign w_overrun_rise = OVERRUN_ERROR_IN & ~r_overrun_d;

    always_comb begin
        w_err_set                   = '0;
        w_err_set[c_err_bit_parity]  = w_parity_rise;
        w_err_set[c_err_bit_frame]   = w_frame_rise;
        w_err_set[c_err_bit_overrun] = w_overrun_rise;
        w_err_set[c_err_bit_drop]    = w_drop_evt;
    end

    uart_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .i_push  (w_push),
        .i_data  (RX_DATA_IN),
        .i_pop   (w_pop),
        .o_data  (DATA_OUT),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (FIFO_COUNT)
    );

    assign DATA_VALID  = ~w_empty;
    assign FIFO_FULL   = w_full;
    assign DROP        = r_drop;
    assign ERR_STATUS  = r_err_status;
    assign CFG_ACK     = r_cfg_ack;
    assign PARITY_EN   = r_parity_en;
    assign PARITY_MODE = r_parity_mode;

    // Status, edge detection and drop pulse. A set event beats ERR_CLR.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rx_done_d  <= 1'b0;
            r_frame_d    <= 1'b0;
            r_parity_d   <= 1'b0;
            r_overrun_d  <= 1'b0;
            r_rx_busy_d  <= 1'b0;
            r_drop       <= 1'b0;
            r_err_status <= '0;
        end else begin
            r_rx_done_d  <= RX_DONE;
            r_frame_d    <= FRAME_ERROR_IN;
            r_parity_d   <= PARITY_ERROR_IN;
            r_overrun_d  <= OVERRUN_ERROR_IN;
            r_rx_busy_d  <= RX_BUSY;
            r_drop       <= w_drop_evt;
            r_err_status <= (ERR_CLR ? 4'b0000 : r_err_status) | w_err_set;
        end
    end

    // Configuration hand-shake. The receiver must be idle in this cycle and
    // the previous one, so a configuration is never committed on the edge
    // that closes a frame; the new values and the ACK pulse are registered
    // together on entry to CFG_APPLY.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cfg_state   <= CFG_IDLE;
            r_cfg_ack     <= 1'b0;
            r_parity_en   <= 1'b0;
            r_parity_mode <= 1'b0;
        end else begin
            r_cfg_ack <= 1'b0;
            case (r_cfg_state)
                CFG_IDLE: begin
                    if (CFG_REQ) begin
                        r_cfg_state <= CFG_WAIT;
                    end
                end
                CFG_WAIT: begin
                    if (!CFG_REQ) begin
                        r_cfg_state <= CFG_IDLE;
                    end else if (!RX_BUSY && !r_rx_busy_d && !RX_DONE && !w_push) begin
                        r_cfg_state   <= CFG_APPLY;
                        r_cfg_ack     <= 1'b1;
                        r_parity_en   <= CFG_PARITY_EN;
                        r_parity_mode <= CFG_PARITY_MODE;
                    end
                end
                CFG_APPLY: begin
                    r_cfg_state <= CFG_IDLE;
                end
                default: begin
                    r_cfg_state <= CFG_IDLE;
                end
            endcase
        end
    end

`ifdef UART_RX_CTRL_ERR_CNT_EN
    logic [c_err_cnt_w-1:0] r_frame_cnt;
    logic [c_err_cnt_w-1:0] r_parity_cnt;

    assign FRAME_ERR_CNT  = r_frame_cnt;
    assign PARITY_ERR_CNT = r_parity_cnt;

    // Saturating counters; an error edge coinciding with ERR_CLR counts as 1.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_frame_cnt  <= '0;
            r_parity_cnt <= '0;
        end else begin
            if (ERR_CLR) begin
                r_frame_cnt  <= c_err_cnt_w'(w_frame_rise);
                r_parity_cnt <= c_err_cnt_w'(w_parity_rise);
            end else begin
                if (w_frame_rise && (r_frame_cnt != '1)) begin
                    r_frame_cnt <= r_frame_cnt + c_err_cnt_w'(1);
                end
                if (w_parity_rise && (r_parity_cnt != '1)) begin
                    r_parity_cnt <= r_parity_cnt + c_err_cnt_w'(1);
                end
            end
        end
    end
`endif

endmodule : uart_rx_ctrl
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_ctrl
//  Description : Directed self-checking bench for uart_rx_ctrl (DATA_WIDTH=8,
//                FIFO_DEPTH=4). Counter checks are compiled in only when
//                UART_RX_CTRL_ERR_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       RX_DONE;
    logic [7:0] RX_DATA_IN;
    logic       RX_BUSY;
    logic       PARITY_ERROR_IN;
    logic       FRAME_ERROR_IN;
    logic       OVERRUN_ERROR_IN;
    logic       CFG_REQ;
    logic       CFG_PARITY_EN;
    logic       CFG_PARITY_MODE;
    logic       CFG_ACK;
    logic       PARITY_EN;
    logic       PARITY_MODE;
    logic [7:0] DATA_OUT;
    logic       DATA_VALID;
    logic       DATA_READY;
    logic [2:0] FIFO_COUNT;
    logic       FIFO_FULL;
    logic       DROP;
    logic [3:0] ERR_STATUS;
    logic       ERR_CLR;
`ifdef UART_RX_CTRL_ERR_CNT_EN
    logic [7:0] FRAME_ERR_CNT;
    logic [7:0] PARITY_ERR_CNT;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    uart_rx_ctrl #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .RX_DONE          (RX_DONE),
        .RX_DATA_IN       (RX_DATA_IN),
        .RX_BUSY          (RX_BUSY),
        .PARITY_ERROR_IN  (PARITY_ERROR_IN),
        .FRAME_ERROR_IN   (FRAME_ERROR_IN),
        .OVERRUN_ERROR_IN (OVERRUN_ERROR_IN),
        .CFG_REQ          (CFG_REQ),
        .CFG_PARITY_EN    (CFG_PARITY_EN),
        .CFG_PARITY_MODE  (CFG_PARITY_MODE),
        .CFG_ACK          (CFG_ACK),
        .PARITY_EN        (PARITY_EN),
        .PARITY_MODE      (PARITY_MODE),
        .DATA_OUT         (DATA_OUT),
        .DATA_VALID       (DATA_VALID),
        .DATA_READY       (DATA_READY),
        .FIFO_COUNT       (FIFO_COUNT),
        .FIFO_FULL        (FIFO_FULL),
        .DROP             (DROP),
        .ERR_STATUS       (ERR_STATUS),
        .ERR_CLR          (ERR_CLR)
`ifdef UART_RX_CTRL_ERR_CNT_EN
        ,
        .FRAME_ERR_CNT    (FRAME_ERR_CNT),
        .PARITY_ERR_CNT   (PARITY_ERR_CNT)
`endif
    );

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clean RX_DONE pulse (high one cycle, low one cycle).
    task automatic push_word(input logic [7:0] d);
        RX_DATA_IN = d;
        RX_DONE    = 1'b1;
        tick();
        RX_DONE    = 1'b0;
        tick();
    endtask

    logic ack_seen;
    logic cfg_moved;

    initial begin
        RESET = 1'b1; RX_DONE = 1'b0; RX_DATA_IN = 8'h00; RX_BUSY = 1'b0;
        PARITY_ERROR_IN = 1'b0; FRAME_ERROR_IN = 1'b0; OVERRUN_ERROR_IN = 1'b0;
        CFG_REQ = 1'b0; CFG_PARITY_EN = 1'b0; CFG_PARITY_MODE = 1'b0;
        DATA_READY = 1'b0; ERR_CLR = 1'b0;
        tick(2);

        // ---- reset state
        check("rst_valid",  DATA_VALID, 0);
        check("rst_count",  FIFO_COUNT, 0);
        check("rst_full",   FIFO_FULL, 0);
        check("rst_drop",   DROP, 0);
        check("rst_err",    ERR_STATUS, 0);
        check("rst_ack",    CFG_ACK, 0);
        check("rst_pen",    {PARITY_EN, PARITY_MODE}, 0);
        RESET = 1'b0;
        tick();

        // ---- RX_DONE held 3 cycles -> exactly one word, visible one cycle later
        RX_DATA_IN = 8'hA5; RX_DONE = 1'b1;
        tick();
        check("push_valid", DATA_VALID, 1);
        check("push_data",  DATA_OUT, 8'hA5);
        check("push_count", FIFO_COUNT, 1);
        tick(2);
        check("hold_count", FIFO_COUNT, 1);
        RX_DONE = 1'b0;
        tick();
        DATA_READY = 1'b1;
        tick();
        check("pop_count",  FIFO_COUNT, 0);
        check("pop_valid",  DATA_VALID, 0);

        // ---- pop while empty is ignored, push with ready held drains next edge
        tick(2);
        check("empty_pop",  FIFO_COUNT, 0);
        RX_DATA_IN = 8'h11; RX_DONE = 1'b1;
        tick();
        check("fwft_count", FIFO_COUNT, 1);
        check("fwft_data",  DATA_OUT, 8'h11);
        RX_DONE = 1'b0;
        tick();
        check("fwft_drain", FIFO_COUNT, 0);
        DATA_READY = 1'b0;

        // ---- overfill: 4 accepted, fifth dropped
        push_word(8'hA1);
        push_word(8'hA2);
        push_word(8'hA3);
        push_word(8'hA4);
        check("fill_count", FIFO_COUNT, 4);
        check("fill_full",  FIFO_FULL, 1);
        check("fill_drop0", DROP, 0);
        RX_DATA_IN = 8'h5A; RX_DONE = 1'b1;
        tick();
        check("ovf_drop",   DROP, 1);
        check("ovf_err",    ERR_STATUS, 4'b1000);
        check("ovf_count",  FIFO_COUNT, 4);
        RX_DONE = 1'b0;
        tick();
        check("ovf_drop1",  DROP, 0);
        check("ovf_head",   DATA_OUT, 8'hA1);

        // ---- full FIFO, push 0x3C with simultaneous pop
        RX_DATA_IN = 8'h3C; RX_DONE = 1'b1; DATA_READY = 1'b1;
        tick();
        check("pp_count",   FIFO_COUNT, 4);
        check("pp_drop",    DROP, 0);
        check("pp_head",    DATA_OUT, 8'hA2);
        RX_DONE = 1'b0;
        tick();
        check("drain_a3",   DATA_OUT, 8'hA3);
        check("drain_c3",   FIFO_COUNT, 3);
        tick();
        check("drain_a4",   DATA_OUT, 8'hA4);
        tick();
        check("drain_3c",   DATA_OUT, 8'h3C);
        check("drain_c1",   FIFO_COUNT, 1);
        tick();
        check("drain_c0",   FIFO_COUNT, 0);
        DATA_READY = 1'b0;
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        check("clr_drop",   ERR_STATUS, 0);

        // ---- configuration held off while busy, ACK 2 cycles after busy falls
        RX_BUSY = 1'b1; CFG_PARITY_EN = 1'b1; CFG_PARITY_MODE = 1'b1; CFG_REQ = 1'b1;
        ack_seen = 1'b0; cfg_moved = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            ack_seen  = ack_seen | CFG_ACK;
            cfg_moved = cfg_moved | PARITY_EN | PARITY_MODE;
        end
        check("busy_noack", ack_seen, 0);
        check("busy_nocfg", cfg_moved, 0);
        RX_BUSY = 1'b0;
        tick();
        check("cfg_ack_1",  CFG_ACK, 0);
        tick();
        check("cfg_ack_2",  CFG_ACK, 1);
        check("cfg_vals",   {PARITY_EN, PARITY_MODE}, 2'b11);
        CFG_REQ = 1'b0;
        tick();
        check("cfg_ack_pl", CFG_ACK, 0);
        check("cfg_keep",   {PARITY_EN, PARITY_MODE}, 2'b11);

        // ---- request withdrawn while waiting: nothing applied
        RX_BUSY = 1'b1; CFG_PARITY_EN = 1'b0; CFG_PARITY_MODE = 1'b0; CFG_REQ = 1'b1;
        tick(2);
        CFG_REQ = 1'b0;
        tick();
        RX_BUSY = 1'b0;
        ack_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            ack_seen = ack_seen | CFG_ACK;
        end
        check("abort_ack",  ack_seen, 0);
        check("abort_cfg",  {PARITY_EN, PARITY_MODE}, 2'b11);

        // ---- minimum latency with receiver idle
        CFG_PARITY_EN = 1'b0; CFG_PARITY_MODE = 1'b1; CFG_REQ = 1'b1;
        tick();
        check("min_ack_1",  CFG_ACK, 0);
        tick();
        check("min_ack_2",  CFG_ACK, 1);
        check("min_vals",   {PARITY_EN, PARITY_MODE}, 2'b01);
        CFG_REQ = 1'b0;
        tick();

        // ---- frame error pulsed three times, then clear
        for (int i = 0; i < 3; i++) begin
            FRAME_ERROR_IN = 1'b1;
            tick();
            FRAME_ERROR_IN = 1'b0;
            tick();
        end
        check("frame_err",  ERR_STATUS, 4'b0010);
`ifdef UART_RX_CTRL_ERR_CNT_EN
        check("frame_cnt",  FRAME_ERR_CNT, 3);
        check("par_cnt0",   PARITY_ERR_CNT, 0);
`endif
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        check("frame_clr",  ERR_STATUS, 0);
`ifdef UART_RX_CTRL_ERR_CNT_EN
        check("fcnt_clr",   FRAME_ERR_CNT, 0);
`endif

        // ---- parity and overrun bits; levels held high do not re-trigger
        PARITY_ERROR_IN = 1'b1;
        tick();
        check("par_err",    ERR_STATUS, 4'b0001);
        OVERRUN_ERROR_IN = 1'b1;
        tick();
        check("ovr_err",    ERR_STATUS, 4'b0101);
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        check("lvl_clr",    ERR_STATUS, 0);
        PARITY_ERROR_IN = 1'b0; OVERRUN_ERROR_IN = 1'b0;

        // ---- set event wins over a same-cycle clear
        FRAME_ERROR_IN = 1'b1; ERR_CLR = 1'b1;
        tick();
        FRAME_ERROR_IN = 1'b0; ERR_CLR = 1'b0;
        check("set_wins",   ERR_STATUS, 4'b0010);
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;

        // ---- reset with 2 words buffered
        push_word(8'h77);
        push_word(8'h88);
        check("pre_rst_c",  FIFO_COUNT, 2);
        RESET = 1'b1;
        #1;
        check("arst_valid", DATA_VALID, 0);
        check("arst_count", FIFO_COUNT, 0);
        check("arst_cfg",   {PARITY_EN, PARITY_MODE}, 0);
        tick();
        RESET = 1'b0;
        tick();
        check("post_valid", DATA_VALID, 0);
        check("post_count", FIFO_COUNT, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_rx_ctrl
`default_nettype wire

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameters SHALL be DATA_WIDTH (default 8, received word width) and FIFO_DEPTH (default 4, power of two ≥2, receive buffer entries).
REQ-002 Ports SHALL be as follows:
- CLK  in  1  single system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- RX_DONE  in  1  receiver word-complete flag.
- RX_DATA_IN  in  DATA_WIDTH  receiver data.
- RX_BUSY  in  1  high while the receiver is not in IDLE.
- PARITY_ERROR_IN, FRAME_ERROR_IN, OVERRUN_ERROR_IN  in  1 each  receiver error flags.
- CFG_REQ  in  1  configuration request, held high until CFG_ACK.
- CFG_PARITY_EN, CFG_PARITY_MODE  in  1 each  requested configuration.
- CFG_ACK  out  1  one-cycle pulse when configuration is applied.
- PARITY_EN, PARITY_MODE  out  1 each  registered configuration driven to the receiver.
- DATA_OUT  out  DATA_WIDTH  FIFO head word.
- DATA_VALID  out  1  FIFO non-empty.
- DATA_READY  in  1  consumer accepts the head word when DATA_VALID is high.
- FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  occupancy.
- FIFO_FULL  out  1  occupancy equals FIFO_DEPTH.
- DROP  out  1  one-cycle pulse when a word is lost because the FIFO is full.
- ERR_STATUS  out  4  sticky flags {drop, overrun, frame, parity}.
- ERR_CLR  in  1  clears ERR_STATUS (and counters when enabled).
- FRAME_ERR_CNT, PARITY_ERR_CNT  out  8 each  error counters, present only with the macro.

Function
REQ-003 RX_DONE SHALL be edge-detected: a push event occurs in the first cycle RX_DONE is high after a cycle in which it was low.
REQ-004 On a push event, RX_DATA_IN SHALL be written at that clock edge; DATA_VALID SHALL be high the next cycle; latency is 1 cycle.
REQ-005 A pop SHALL occur in any cycle where DATA_VALID and DATA_READY are both high; DATA_OUT SHALL advance at that edge.
REQ-006 A simultaneous push and pop SHALL leave FIFO_COUNT unchanged, including when the FIFO is full.
REQ-007 A push while full without a pop SHALL discard the word, pulse DROP for 1 cycle, and set ERR_STATUS[3].
REQ-008 A pop while empty SHALL be ignored; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-009 Rising edges of FRAME_ERROR_IN, PARITY_ERROR_IN, and OVERRUN_ERROR_IN SHALL set ERR_STATUS[1], [0], and [2] respectively.
REQ-010 ERR_CLR SHALL clear ERR_STATUS at the next edge; a set event in the same cycle SHALL win.
REQ-011 The configuration FSM SHALL have states CFG_IDLE, CFG_WAIT, and CFG_APPLY.
REQ-012 CFG_IDLE SHALL move to CFG_WAIT when CFG_REQ is high.
REQ-013 CFG_WAIT SHALL move to CFG_APPLY only in a cycle with RX_BUSY=0, RX_DONE=0, and no push event.
REQ-014 CFG_APPLY SHALL load PARITY_EN and PARITY_MODE, pulse CFG_ACK, and return to CFG_IDLE.
REQ-015 The minimum request-to-ACK latency SHALL be 2 cycles.
REQ-016 PARITY_EN and PARITY_MODE SHALL never change while RX_BUSY=1.
REQ-017 If CFG_REQ drops while in CFG_WAIT, the FSM SHALL return to CFG_IDLE without applying the configuration.

Reset
REQ-018 RESET SHALL asynchronously clear FIFO pointers and counts, ERR_STATUS, counters, edge-detect registers, DROP, CFG_ACK, PARITY_EN, and PARITY_MODE to 0, and set the FSM to CFG_IDLE.
REQ-019 Reset mid-operation SHALL discard buffered words; DATA_VALID SHALL be 0 on the first cycle after deassertion.

Configuration
REQ-020 With macro UART_RX_CTRL_ERR_CNT_EN defined, FRAME_ERR_CNT and PARITY_ERR_CNT SHALL increment on the same edges as REQ-009, saturate at 255, and clear on ERR_CLR.
REQ-021 Without the macro, the counter ports and logic SHALL be absent.

Structure
REQ-022 A shared package SHALL hold the config-FSM state enum, the ERR_STATUS bit-index constants, and the counter width (8).
REQ-023 The FIFO SHALL be a sub-module named uart_rx_fifo (parameters DATA_WIDTH, FIFO_DEPTH; push/pop/full/empty/count).

Verification
REQ-024 The bench SHALL cover these scenarios:
- Push 0xA5: RX_DONE high for 3 cycles → exactly one word; DATA_OUT=0xA5, FIFO_COUNT=1 one cycle later.
- 5 pushes with DATA_READY=0, FIFO_DEPTH=4 → FIFO_FULL=1, fifth word dropped, DROP pulses once, ERR_STATUS=4'b1000.
- Full FIFO, push 0x3C with a simultaneous pop → FIFO_COUNT stays 4, 0x3C read out last.
- CFG_REQ with EN=1, MODE=1 while RX_BUSY=1 for 10 cycles → no change; CFG_ACK 2 cycles after RX_BUSY falls; PARITY_EN=1, PARITY_MODE=1.
- FRAME_ERROR_IN pulsed 3 times, then ERR_CLR → ERR_STATUS[1]=1 and (macro on) FRAME_ERR_CNT=3; then both return to 0.
- RESET asserted with 2 words buffered → DATA_VALID=0 and FIFO_COUNT=0 immediately.
